// File: rtl/addr4u_check_stage_pkg.sv
// Shared types and widths for the 4-bit unsigned adder checker.
package addr4u_check_stage_pkg;

  localparam int OP_W  = 4;
  localparam int SUM_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/addr4u_golden.sv
// Reference model of the adder under test: golden sum and equality compare.
module addr4u_golden
  import addr4u_check_stage_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [SUM_W-1:0] sum_dut,
  output logic [SUM_W-1:0] golden,
  output logic             pass
);

  // Operands are zero-extended so the carry lands in bit 4; 15+15 fits in 5 bits.
  assign golden = {1'b0, a} + {1'b0, b};
  assign pass   = (sum_dut == golden);

endmodule

// File: rtl/addr4u_check_stage.sv
// Check stage for a 4-bit unsigned adder: one-beat skid-free pipeline register,
// saturating beat/error counters and first-failure capture.
module addr4u_check_stage
  import addr4u_check_stage_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int HALT_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [SUM_W-1:0] sum_dut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             fail_sticky,
  output logic [OP_W-1:0]  ff_a,
  output logic [OP_W-1:0]  ff_b,
  output logic [SUM_W-1:0] ff_sum
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state;
  logic [SUM_W-1:0] golden;
  logic             pass;
  logic             accept;

  addr4u_golden u_golden (
    .a       (a),
    .b       (b),
    .sum_dut (sum_dut),
    .golden  (golden),
    .pass    (pass)
  );

  // Ready never looks at in_valid or the operands, so no input-to-output comb path.
  assign in_ready = en && !clr && (state == ST_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: all state below uses non-blocking assignment so every register samples
  // the pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_pass    <= 1'b0;
      err_cnt     <= '0;
      beat_cnt    <= '0;
      fail_sticky <= 1'b0;
      ff_a        <= '0;
      ff_b        <= '0;
      ff_sum      <= '0;
    end else begin
      // Output register drains independently of clr/en so a pending beat is never lost.
      if (accept) begin
        out_valid <= 1'b1;
        out_sum   <= sum_dut;
        out_pass  <= pass;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (clr) begin
        err_cnt     <= '0;
        beat_cnt    <= '0;
        fail_sticky <= 1'b0;
        ff_a        <= '0;
        ff_b        <= '0;
        ff_sum      <= '0;
        state       <= en ? ST_RUN : ST_IDLE;
      end else begin
        if (accept) begin
          if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + CNT_W'(1);
          if (!pass) begin
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
            if (!fail_sticky) begin
              fail_sticky <= 1'b1;
              ff_a        <= a;
              ff_b        <= b;
              ff_sum      <= sum_dut;
            end
          end
        end

        case (state)
          ST_IDLE: if (en) state <= ST_RUN;
          ST_RUN: begin
            if (!en)                                        state <= ST_IDLE;
            else if (accept && !pass && HALT_ON_FAIL != 0)  state <= ST_HALT;
          end
          ST_HALT: state <= ST_HALT;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_addr4u_check_stage.sv
// Directed bench for addr4u_check_stage: default, CNT_W=2 and HALT_ON_FAIL=1 instances.
module tb_addr4u_check_stage;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, in_valid, out_ready;
  logic [3:0] a, b;
  logic [4:0] sum_dut;

  logic       rdy_d, ov_d, op_d, fs_d;
  logic [4:0] os_d, ffs_d;
  logic [3:0] ffa_d, ffb_d;
  logic [7:0] ec_d, bc_d;

  logic       rdy_s, ov_s, op_s, fs_s;
  logic [4:0] os_s, ffs_s;
  logic [3:0] ffa_s, ffb_s;
  logic [1:0] ec_s, bc_s;

  logic       rdy_h, ov_h, op_h, fs_h;
  logic [4:0] os_h, ffs_h;
  logic [3:0] ffa_h, ffb_h;
  logic [7:0] ec_h, bc_h;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  addr4u_check_stage u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .in_ready(rdy_d),
    .a(a), .b(b), .sum_dut(sum_dut), .out_valid(ov_d), .out_ready(out_ready),
    .out_sum(os_d), .out_pass(op_d), .err_cnt(ec_d), .beat_cnt(bc_d),
    .fail_sticky(fs_d), .ff_a(ffa_d), .ff_b(ffb_d), .ff_sum(ffs_d)
  );

  addr4u_check_stage #(.CNT_W(2), .HALT_ON_FAIL(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .in_ready(rdy_s),
    .a(a), .b(b), .sum_dut(sum_dut), .out_valid(ov_s), .out_ready(out_ready),
    .out_sum(os_s), .out_pass(op_s), .err_cnt(ec_s), .beat_cnt(bc_s),
    .fail_sticky(fs_s), .ff_a(ffa_s), .ff_b(ffb_s), .ff_sum(ffs_s)
  );

  addr4u_check_stage #(.CNT_W(8), .HALT_ON_FAIL(1)) u_halt (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .in_ready(rdy_h),
    .a(a), .b(b), .sum_dut(sum_dut), .out_valid(ov_h), .out_ready(out_ready),
    .out_sum(os_h), .out_pass(op_h), .err_cnt(ec_h), .beat_cnt(bc_h),
    .fail_sticky(fs_h), .ff_a(ffa_h), .ff_b(ffb_h), .ff_sum(ffs_h)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] va, input logic [3:0] vb, input logic [4:0] vs);
    a = va; b = vb; sum_dut = vs; in_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sum_dut = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic start_run();
    do_reset();
    en = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (ov_d !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", ov_d); end
    vectors++; if (os_d !== 5'd0) begin miscompares++; $display("FAIL reset_out_sum got %0d exp 0", os_d); end
    vectors++; if ({ec_d, bc_d} !== 16'd0) begin miscompares++; $display("FAIL reset_counters got %0d/%0d exp 0/0", ec_d, bc_d); end
    vectors++; if ({fs_d, ffa_d, ffb_d, ffs_d} !== 14'd0) begin miscompares++; $display("FAIL reset_capture got %b exp 0", {fs_d, ffa_d, ffb_d, ffs_d}); end
    en = 1'b1; #1;
    vectors++; if (rdy_d !== 1'b0) begin miscompares++; $display("FAIL idle_in_ready got %b exp 0", rdy_d); end
    step();
    vectors++; if (rdy_d !== 1'b1) begin miscompares++; $display("FAIL run_in_ready got %b exp 1", rdy_d); end
  endtask

  task automatic test_basic();
    start_run();
    beat(4'd7, 4'd9, 5'd16);
    step(); in_valid = 1'b0;
    vectors++; if (ov_d !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid got %b exp 1", ov_d); end
    vectors++; if (os_d !== 5'd16) begin miscompares++; $display("FAIL basic_out_sum got %0d exp 16", os_d); end
    vectors++; if (op_d !== 1'b1) begin miscompares++; $display("FAIL basic_out_pass got %b exp 1", op_d); end
    vectors++; if (bc_d !== 8'd1 || ec_d !== 8'd0) begin miscompares++; $display("FAIL basic_cnts got %0d/%0d exp 1/0", bc_d, ec_d); end
    step();
    vectors++; if (ov_d !== 1'b0) begin miscompares++; $display("FAIL basic_drain got %b exp 0", ov_d); end
  endtask

  task automatic test_mismatch();
    start_run();
    beat(4'd15, 4'd15, 5'd30);
    step();
    vectors++; if (os_d !== 5'd30 || op_d !== 1'b1) begin miscompares++; $display("FAIL carry_beat got %0d/%b exp 30/1", os_d, op_d); end
    beat(4'd3, 4'd4, 5'd8);
    step();
    beat(4'd1, 4'd1, 5'd5);
    vectors++; if (op_d !== 1'b0) begin miscompares++; $display("FAIL mis_out_pass got %b exp 0", op_d); end
    vectors++; if (ec_d !== 8'd1 || fs_d !== 1'b1) begin miscompares++; $display("FAIL mis_err got %0d/%b exp 1/1", ec_d, fs_d); end
    vectors++; if ({ffa_d, ffb_d, ffs_d} !== {4'd3, 4'd4, 5'd8}) begin miscompares++; $display("FAIL mis_capture got %0d,%0d,%0d exp 3,4,8", ffa_d, ffb_d, ffs_d); end
    step(); in_valid = 1'b0;
    vectors++; if (ec_d !== 8'd2 || bc_d !== 8'd3) begin miscompares++; $display("FAIL mis2_cnts got %0d/%0d exp 2/3", ec_d, bc_d); end
    vectors++; if ({ffa_d, ffb_d, ffs_d} !== {4'd3, 4'd4, 5'd8}) begin miscompares++; $display("FAIL mis2_capture_kept got %0d,%0d,%0d exp 3,4,8", ffa_d, ffb_d, ffs_d); end
  endtask

  task automatic test_back_to_back();
    start_run();
    out_ready = 1'b0;
    beat(4'd1, 4'd2, 5'd3);
    step();
    beat(4'd2, 4'd2, 5'd4);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (rdy_d !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d] got %b exp 0", i, rdy_d); end
      vectors++; if (ov_d !== 1'b1 || os_d !== 5'd3 || bc_d !== 8'd1) begin miscompares++; $display("FAIL stall_hold[%0d] got %b/%0d/%0d exp 1/3/1", i, ov_d, os_d, bc_d); end
      step();
    end
    out_ready = 1'b1; #1;
    vectors++; if (rdy_d !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b exp 1", rdy_d); end
    step();
    vectors++; if (os_d !== 5'd4 || bc_d !== 8'd2) begin miscompares++; $display("FAIL release_b got %0d/%0d exp 4/2", os_d, bc_d); end
    beat(4'd5, 4'd5, 5'd10);
    step(); in_valid = 1'b0;
    vectors++; if (ov_d !== 1'b1 || os_d !== 5'd10 || bc_d !== 8'd3) begin miscompares++; $display("FAIL release_c got %b/%0d/%0d exp 1/10/3", ov_d, os_d, bc_d); end
    step();
    vectors++; if (ov_d !== 1'b0 || bc_d !== 8'd3) begin miscompares++; $display("FAIL release_drain got %b/%0d exp 0/3", ov_d, bc_d); end
  endtask

  task automatic test_en_clr();
    start_run();
    beat(4'd2, 4'd3, 5'd9);
    step();
    en = 1'b0; #1;
    vectors++; if (rdy_d !== 1'b0) begin miscompares++; $display("FAIL en_low_in_ready got %b exp 0", rdy_d); end
    step(); step();
    vectors++; if (bc_d !== 8'd1 || ec_d !== 8'd1 || ffs_d !== 5'd9 || ov_d !== 1'b0) begin miscompares++; $display("FAIL en_low_retain got %0d/%0d/%0d/%b exp 1/1/9/0", bc_d, ec_d, ffs_d, ov_d); end
    en = 1'b1; clr = 1'b1; #1;
    vectors++; if (rdy_d !== 1'b0) begin miscompares++; $display("FAIL clr_in_ready got %b exp 0", rdy_d); end
    step(); clr = 1'b0; #1;
    vectors++; if (bc_d !== 8'd0 || ec_d !== 8'd0 || fs_d !== 1'b0 || ffs_d !== 5'd0 || ov_d !== 1'b0) begin miscompares++; $display("FAIL clr_no_accept got %0d/%0d/%b/%0d/%b exp 0/0/0/0/0", bc_d, ec_d, fs_d, ffs_d, ov_d); end
    vectors++; if (rdy_d !== 1'b1) begin miscompares++; $display("FAIL clr_to_run got %b exp 1", rdy_d); end
    in_valid = 1'b0;
  endtask

  task automatic test_saturate();
    start_run();
    beat(4'd1, 4'd1, 5'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 2) begin
        vectors++; if (ec_s !== 2'd2 || bc_s !== 2'd2) begin miscompares++; $display("FAIL sat_mid got %0d/%0d exp 2/2", ec_s, bc_s); end
      end
    end
    in_valid = 1'b0;
    vectors++; if (ec_s !== 2'd3 || bc_s !== 2'd3) begin miscompares++; $display("FAIL sat_hold got %0d/%0d exp 3/3", ec_s, bc_s); end
    vectors++; if (ec_d !== 8'd5 || bc_d !== 8'd5) begin miscompares++; $display("FAIL wide_cnt got %0d/%0d exp 5/5", ec_d, bc_d); end
  endtask

  task automatic test_halt();
    start_run();
    beat(4'd1, 4'd1, 5'd0);
    step();
    beat(4'd2, 4'd2, 5'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (rdy_h !== 1'b0 || bc_h !== 8'd1) begin miscompares++; $display("FAIL halt_block[%0d] got %b/%0d exp 0/1", i, rdy_h, bc_h); end
      step();
    end
    vectors++; if (bc_d !== 8'd4) begin miscompares++; $display("FAIL nohalt_cnt got %0d exp 4", bc_d); end
    clr = 1'b1;
    step(); clr = 1'b0; #1;
    vectors++; if (bc_h !== 8'd0 || ec_h !== 8'd0 || fs_h !== 1'b0 || ffa_h !== 4'd0) begin miscompares++; $display("FAIL halt_clr got %0d/%0d/%b/%0d exp 0/0/0/0", bc_h, ec_h, fs_h, ffa_h); end
    vectors++; if (rdy_h !== 1'b1) begin miscompares++; $display("FAIL halt_clr_run got %b exp 1", rdy_h); end
    step(); in_valid = 1'b0;
    vectors++; if (bc_h !== 8'd1 || op_h !== 1'b1 || os_h !== 5'd4) begin miscompares++; $display("FAIL halt_resume got %0d/%b/%0d exp 1/1/4", bc_h, op_h, os_h); end
  endtask

  task automatic test_reset_mid();
    start_run();
    out_ready = 1'b0;
    beat(4'd7, 4'd9, 5'd16);
    step(); in_valid = 1'b0;
    vectors++; if (ov_d !== 1'b1) begin miscompares++; $display("FAIL pre_rst_valid got %b exp 1", ov_d); end
    rst_n = 1'b0; clr = 1'b1;
    step();
    vectors++; if ({ov_d, os_d, op_d} !== 7'd0) begin miscompares++; $display("FAIL mid_rst_out got %b/%0d/%b exp 0/0/0", ov_d, os_d, op_d); end
    vectors++; if ({ec_d, bc_d, fs_d} !== 17'd0) begin miscompares++; $display("FAIL mid_rst_cnt got %0d/%0d/%b exp 0/0/0", ec_d, bc_d, fs_d); end
    rst_n = 1'b1; clr = 1'b0; out_ready = 1'b1; #1;
    vectors++; if (rdy_d !== 1'b0) begin miscompares++; $display("FAIL mid_rst_idle got %b exp 0", rdy_d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_back_to_back();
    test_en_clr();
    test_saturate();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/addr4u_check_stage.md
ADDR4U_CHECK_STAGE -- requirements
Module: addr4u_check_stage

Interface
REQ-001 Parameter CNT_W, default 8, width of error and beat counters.
REQ-002 Parameter HALT_ON_FAIL, default 0; 1 = stop accepting beats after first mismatch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  enables checking; low = block idle, in_ready low.
REQ-006 clr  input  1  synchronous clear of counters, sticky flag, capture registers.
REQ-007 in_valid  input  1  upstream beat valid.
REQ-008 in_ready  output  1  block can accept a beat.
REQ-009 a, b  input  4 each  operands driven into the 4-bit unsigned adder under test.
REQ-010 sum_dut  input  5  adder result, bit 4 = carry-out.
REQ-011 out_valid  output  1  registered result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_sum  output  5  registered sum_dut of accepted beat.
REQ-014 out_pass  output  1  registered compare result, 1 = sum_dut equals a+b.
REQ-015 err_cnt, beat_cnt  output  CNT_W each  mismatch count, accepted-beat count.
REQ-016 fail_sticky  output  1  set on any mismatch since reset/clr.
REQ-017 ff_a, ff_b  output  4 each; ff_sum  output  5  operands/result of first mismatching beat.

Function
REQ-018 Beat accepted when in_valid && in_ready; in_ready = en && !clr && state==RUN && (!out_valid || out_ready).
REQ-019 Golden sum = zero-extended a + zero-extended b, 5 bits, no overflow possible; out_pass = (sum_dut == golden).
REQ-020 Latency one cycle: accepted beat appears on out_valid/out_sum/out_pass the following cycle.
REQ-021 out_valid held with stable out_sum/out_pass until out_ready; accept and drain in same cycle is full throughput (one beat per cycle).
REQ-022 beat_cnt increments per accepted beat; err_cnt increments per accepted mismatch; both saturate at 2^CNT_W-1, never wrap.
REQ-023 fail_sticky and ff_* load only on first mismatch (fail_sticky==0); later mismatches do not overwrite.
REQ-024 FSM states: IDLE, RUN, HALT.
REQ-025 IDLE -> RUN when en=1; RUN -> IDLE when en=0 (pending out_valid beat still drains).
REQ-026 RUN -> HALT on accepted mismatch when HALT_ON_FAIL=1; HALT holds in_ready=0 until clr.
REQ-027 clr has priority over acceptance: no beat accepted in a clr cycle; next state IDLE if en=0 else RUN; out_valid, if set, remains until drained.
REQ-028 en low mid-stream: no new acceptance; counters and captures retained.

Reset
REQ-029 On rst_n=0 at clk edge: state IDLE, out_valid 0, out_sum 0, out_pass 0, err_cnt 0, beat_cnt 0, fail_sticky 0, ff_a/ff_b/ff_sum 0.
REQ-030 Reset mid-beat discards the registered beat without handshake; rst_n dominates clr and en.

Structure
REQ-031 Shared package holds the FSM state enum (2-bit), operand width 4 and sum width 5 constants.
REQ-032 One sub-module, addr4u_golden, computes golden sum and compare combinationally; counters/FSM in top.
REQ-033 No combinational path from in_valid or operands to any output; in_ready depends only on state, en, clr, out_valid, out_ready.

Verification
REQ-034 a=7,b=9,sum_dut=16, out_ready=1 -> next cycle out_valid=1, out_sum=16, out_pass=1, beat_cnt=1, err_cnt=0.
REQ-035 a=15,b=15,sum_dut=30 then a=3,b=4,sum_dut=8 -> second out_pass=0, err_cnt=1, fail_sticky=1, ff_a=3, ff_b=4, ff_sum=8.
REQ-036 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_sum stable, no beat lost or duplicated; release -> one beat/cycle.
REQ-037 CNT_W=2, 5 mismatching beats -> err_cnt=3 held, beat_cnt=3 held.
REQ-038 HALT_ON_FAIL=1, mismatch then valid beats -> in_ready=0 in HALT; clr with en=1 -> RUN, counters 0, fail_sticky 0.
REQ-039 rst_n=0 while out_valid=1 and out_ready=0 -> next cycle all outputs 0, state IDLE.
